// File: rtl/pipe_arbiter_pkg.sv
// Shared types and helpers for the round-robin pipe arbiter.
// The PIPE_ARB_LOCK_EN build uses arb_state_t for its packet-lock FSM.
package pipe_arbiter_pkg;

    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    typedef enum logic {
        ARB_FREE   = 1'b0,
        ARB_LOCKED = 1'b1
    } arb_state_t;

endpackage

// File: rtl/pipe_arbiter_if.sv
// dti valid/ready handshake bundle: data and valid flow producer -> consumer,
// and ready flows back from consumer to producer.
interface dti #(
    parameter int W = 16
);
    logic [W-1:0] data;
    logic         valid;
    logic         ready;

    modport producer (output data, output valid, input ready);
    modport consumer (input data, input valid, output ready);
endinterface

// File: rtl/pipe_arbiter_rr_prio_enc.sv
// Combinational round-robin picker: the first requester at or after ptr, wrapping
// at NUM. NUM does not need to be a power of two.
module rr_prio_enc
    import pipe_arbiter_pkg::*;
#(
    parameter int NUM   = 2,
    parameter int W_IDX = idx_width(NUM)
) (
    input  logic [NUM-1:0]   req,
    input  logic [W_IDX-1:0] ptr,
    output logic [W_IDX-1:0] grant,
    output logic             gvalid
);

    logic [W_IDX:0]   sum  [NUM];
    logic [W_IDX-1:0] cand [NUM];

    // cand[k] is the index examined k-th in the search, i.e. (ptr + k) mod NUM.
    for (genvar gi = 0; gi < NUM; gi++) begin : g_cand
        assign sum[gi]  = {1'b0, ptr} + (W_IDX+1)'(gi);
        assign cand[gi] = (sum[gi] >= (W_IDX+1)'(NUM))
                        ? W_IDX'(sum[gi] - (W_IDX+1)'(NUM))
                        : sum[gi][W_IDX-1:0];
    end

    // Walk from the lowest priority upward so that the closest match to ptr wins.
    always_comb begin
        grant  = '0;
        gvalid = 1'b0;
        for (int k = NUM - 1; k >= 0; k--) begin
            if (req[cand[k]]) begin
                grant  = cand[k];
                gvalid = 1'b1;
            end
        end
    end

endmodule

// File: rtl/pipe_arbiter.sv
// N-input round-robin arbiter feeding a single registered output stage tagged with the source index.
// Defining PIPE_ARB_LOCK_EN holds the grant on one source until a word with data[DIN-1]=1 (eot) transfers.
module pipe_arbiter
    import pipe_arbiter_pkg::*;
#(
    parameter int NUM = 2,
    parameter int DIN = 16
) (
    input  logic  clk,
    input  logic  rst,
    dti.consumer  din [NUM-1:0],
    dti.producer  dout
);

    localparam int W_IDX = idx_width(NUM);
    localparam int DW    = DIN + W_IDX;

    logic [NUM-1:0]   req;
    logic [DIN-1:0]   in_data [NUM];
    logic [W_IDX-1:0] rr_grant;
    logic             rr_gvalid;
    logic [W_IDX-1:0] grant;
    logic             gvalid;
    logic             load;
    logic             xfer;
    logic [DIN-1:0]   sel_data;

    logic             out_valid_reg, out_valid_next;
    logic [DW-1:0]    out_data_reg,  out_data_next;
    logic [W_IDX-1:0] ptr_reg,       ptr_next;

    function automatic logic [W_IDX-1:0] wrap_inc(input logic [W_IDX-1:0] v);
        return (int'(v) >= NUM - 1) ? '0 : v + W_IDX'(1);
    endfunction

    for (genvar gi = 0; gi < NUM; gi++) begin : g_in
        assign req[gi]        = din[gi].valid;
        assign in_data[gi]    = din[gi].data;
        assign din[gi].ready  = xfer && (grant == W_IDX'(gi));
    end

    rr_prio_enc #(
        .NUM   (NUM),
        .W_IDX (W_IDX)
    ) u_enc (
        .req    (req),
        .ptr    (ptr_reg),
        .grant  (rr_grant),
        .gvalid (rr_gvalid)
    );

    // Readies are held low while rst is asserted so no producer sees a transfer that reset discards.
    assign load     = !rst && (!out_valid_reg || dout.ready);
    assign xfer     = load && gvalid;
    assign sel_data = in_data[grant];

`ifdef PIPE_ARB_LOCK_EN
    arb_state_t       state_reg, state_next;
    logic [W_IDX-1:0] lock_idx_reg, lock_idx_next;
    logic             eot;

    assign eot    = sel_data[DIN-1];
    assign grant  = (state_reg == ARB_LOCKED) ? lock_idx_reg : rr_grant;
    assign gvalid = (state_reg == ARB_LOCKED) ? req[lock_idx_reg] : rr_gvalid;
`else
    assign grant  = rr_grant;
    assign gvalid = rr_gvalid;
`endif

    always_comb begin
        out_valid_next = out_valid_reg;
        out_data_next  = out_data_reg;
        ptr_next       = ptr_reg;
`ifdef PIPE_ARB_LOCK_EN
        state_next     = state_reg;
        lock_idx_next  = lock_idx_reg;
`endif
        if (xfer) begin
            out_valid_next = 1'b1;
            out_data_next  = {grant, sel_data};
`ifdef PIPE_ARB_LOCK_EN
            // Priority only rotates once a packet completes; mid-packet words leave ptr alone.
            if (state_reg == ARB_FREE) begin
                if (eot) begin
                    ptr_next = wrap_inc(grant);
                end else begin
                    state_next    = ARB_LOCKED;
                    lock_idx_next = grant;
                end
            end else if (eot) begin
                state_next = ARB_FREE;
                ptr_next   = wrap_inc(lock_idx_reg);
            end
`else
            ptr_next = wrap_inc(grant);
`endif
        end else if (dout.ready) begin
            out_valid_next = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid_reg <= 1'b0;
            out_data_reg  <= '0;
            ptr_reg       <= '0;
`ifdef PIPE_ARB_LOCK_EN
            state_reg     <= ARB_FREE;
            lock_idx_reg  <= '0;
`endif
        end else begin
            out_valid_reg <= out_valid_next;
            out_data_reg  <= out_data_next;
            ptr_reg       <= ptr_next;
`ifdef PIPE_ARB_LOCK_EN
            state_reg     <= state_next;
            lock_idx_reg  <= lock_idx_next;
`endif
        end
    end

    assign dout.valid = out_valid_reg;
    assign dout.data  = out_data_reg;

endmodule

// File: tb/tb_pipe_arbiter.sv
// Self-checking bench for pipe_arbiter (NUM=3, DIN=16): directed scenarios followed by random traffic,
// all checked against a transaction-level reference model.
module tb_pipe_arbiter;
    import pipe_arbiter_pkg::*;

    localparam int NUM   = 3;
    localparam int DIN   = 16;
    localparam int W_IDX = idx_width(NUM);
    localparam int DW    = DIN + W_IDX;
`ifdef PIPE_ARB_LOCK_EN
    localparam bit LOCK = 1'b1;
`else
    localparam bit LOCK = 1'b0;
`endif
    localparam logic [DIN-1:0] EOT = LOCK ? 16'h8000 : 16'h0000;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic [NUM-1:0] vld = '0;
    logic [DIN-1:0] dat [NUM];
    logic [NUM-1:0] rdy;
    logic           dout_ready = 1'b0;

    dti #(.W(DIN)) din_if [NUM-1:0] ();
    dti #(.W(DW))  dout_if ();

    for (genvar gi = 0; gi < NUM; gi++) begin : g_drv
        assign din_if[gi].valid = vld[gi];
        assign din_if[gi].data  = dat[gi];
        assign rdy[gi]          = din_if[gi].ready;
    end
    assign dout_if.ready = dout_ready;

    pipe_arbiter #(.NUM(NUM), .DIN(DIN)) dut (
        .clk  (clk),
        .rst  (rst),
        .din  (din_if),
        .dout (dout_if)
    );

    // Reference model state
    bit            m_valid;
    logic [DW-1:0] m_data;
    int            m_ptr;
    bit            m_lock;
    int            m_lock_idx;
    int            last_xfer;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Which input should win this cycle, or -1 when none may be granted.
    function automatic int m_grant();
        if (LOCK && m_lock)
            return vld[m_lock_idx] ? m_lock_idx : -1;
        for (int k = 0; k < NUM; k++) begin
            int i = (m_ptr + k) % NUM;
            if (vld[i]) return i;
        end
        return -1;
    endfunction

    task automatic model_reset();
        m_valid = 1'b0; m_data = '0; m_ptr = 0; m_lock = 1'b0; m_lock_idx = 0; last_xfer = -1;
    endtask

    // Called at negedge with inputs already set: check outputs and readies, then advance one edge.
    task automatic cycle(input string tag);
        int g;
        bit ld;
        logic [NUM-1:0] exp_rdy;
        logic [DIN-1:0] wd;
        #1;
        g  = m_grant();
        ld = !rst && (!m_valid || dout_ready);
        exp_rdy = (ld && g >= 0) ? NUM'(1 << g) : '0;
        check({tag, "/dout_valid"}, 32'(dout_if.valid), 32'(m_valid));
        check({tag, "/dout_data"},  32'(dout_if.data),  32'(m_data));
        check({tag, "/din_ready"},  32'(rdy),           32'(exp_rdy));
        @(posedge clk);
        last_xfer = -1;
        if (rst) begin
            model_reset();
        end else if (ld && g >= 0) begin
            wd        = dat[g];
            m_data    = {W_IDX'(g), wd};
            m_valid   = 1'b1;
            last_xfer = g;
            if (LOCK && !m_lock && !wd[DIN-1]) begin
                m_lock = 1'b1; m_lock_idx = g;
            end else if (LOCK && m_lock) begin
                if (wd[DIN-1]) begin
                    m_lock = 1'b0; m_ptr = (m_lock_idx + 1) % NUM;
                end
            end else begin
                m_ptr = (g + 1) % NUM;
            end
        end else if (dout_ready) begin
            m_valid = 1'b0;
        end
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        cycle("reset");
        rst = 1'b0;
    endtask

    initial begin
        logic [DW-1:0]  held;
        logic [DW-1:0]  exp_word;
        for (int i = 0; i < NUM; i++) dat[i] = '0;
        model_reset();
        repeat (2) @(posedge clk);
        @(negedge clk);

        // Reset release with idle inputs
        rst = 1'b0;
        repeat (5) cycle("idle");

        // All inputs valid, continuous dout.ready: strict rotation, one word per cycle
        for (int i = 0; i < NUM; i++) dat[i] = EOT | DIN'(16'hA0 + i);
        vld = '1;
        dout_ready = 1'b1;
        for (int c = 0; c < 7; c++) begin
            cycle("rr");
            exp_word = {W_IDX'(c % NUM), EOT | DIN'(16'hA0 + c % NUM)};
            check("rr_seq_valid", 32'(dout_if.valid), 32'd1);
            check("rr_seq_data", 32'(dout_if.data), 32'(exp_word));
        end

        // Only din[2] valid, then din[0] and din[2]: ptr wraps and din[0] wins
        do_reset();
        vld = 3'b100;
        cycle("only2");
        vld = 3'b101;
        #1 check("wrap_ready", 32'(rdy), 32'b001);
        cycle("wrap");

        // Backpressure: word held with dout.ready low, then reload with no bubble
        vld = '1;
        cycle("bp_fill");
        dout_ready = 1'b0;
        held = dout_if.data;
        for (int c = 0; c < 4; c++) begin
            cycle("bp_hold");
            check("bp_stable", 32'(dout_if.data), 32'(held));
        end
        dout_ready = 1'b1;
        #1 check("bp_nobubble", 32'(|rdy), 32'd1);
        cycle("bp_release");

        // Reset while a word is held and ptr=2
        do_reset();
        vld = 3'b010;
        cycle("pre_rst");
        dout_ready = 1'b0;
        vld = '1;
        rst = 1'b1;
        cycle("rst_mid");
        rst = 1'b0;
        check("rst_mid_valid", 32'(dout_if.valid), 32'd0);
        dout_ready = 1'b1;
        #1 check("rst_mid_ptr0", 32'(rdy), 32'b001);
        cycle("post_rst");

`ifdef PIPE_ARB_LOCK_EN
        // Packet lock: din[1] sends a three-word packet while din[0] waits
        do_reset();
        vld = 3'b010;
        dat[1] = 16'h0001;
        cycle("lock_w1");
        vld = 3'b011;
        dat[0] = 16'h8055;
        dat[1] = 16'h0002;
        #1 check("lock_hold_w2", 32'(rdy), 32'b010);
        cycle("lock_w2");
        dat[1] = 16'h8003;
        #1 check("lock_hold_w3", 32'(rdy), 32'b010);
        cycle("lock_w3");
        dat[1] = 16'h8004;
        #1 check("lock_release", 32'(rdy), 32'b001);
        cycle("lock_next");
        check("lock_next_data", 32'(dout_if.data), 32'({W_IDX'(0), 16'h8055}));
`endif

        // Random traffic obeying the dti hold rule
        do_reset();
        vld = '0;
        for (int c = 0; c < 400; c++) begin
            for (int i = 0; i < NUM; i++) begin
                if (last_xfer == i || !vld[i]) begin
                    vld[i] = ($urandom_range(0, 3) != 0);
                    dat[i] = DIN'($urandom);
                end
            end
            dout_ready = ($urandom_range(0, 3) != 0);
            rst = ($urandom_range(0, 99) == 0);
            cycle("rand");
        end
        rst = 1'b0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
